// File: rtl/sm_pkg.sv
// Shared definitions for the sign-magnitude accumulator: FSM state
// encoding and the maximum representable magnitude for an n-bit word.
package sm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } smState_e;

    // Default operand width, and the largest magnitude it can represent.
    localparam int SM_N       = 8;
    localparam int SM_MAX_MAG = (1 << (SM_N - 1)) - 1;

    // Largest magnitude of a w-bit sign-magnitude word: 2^(w-1)-1.
    function automatic int smMaxMag(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/sm_add_sat.sv
// Combinational saturating sign-magnitude adder. Never produces -0.
module sm_add_sat
    import sm_pkg::*;
#(
    parameter int n = 8
) (
    input  logic [n-1:0] a_i,
    input  logic [n-1:0] b_i,
    output logic [n-1:0] sum_o,
    output logic         sat_o
);

    localparam int           MaxMagInt = smMaxMag(n);
    localparam logic [n-1:0] MaxMagW   = MaxMagInt[n-1:0];

    logic [n-2:0] magA;
    logic [n-2:0] magB;
    logic         signA;
    logic         signB;
    logic [n-1:0] magSum;
    logic [n-2:0] resMag;
    logic         resSign;

    assign magA   = a_i[n-2:0];
    assign magB   = b_i[n-2:0];
    assign signA  = a_i[n-1];
    assign signB  = b_i[n-1];
    assign magSum = {1'b0, magA} + {1'b0, magB};

    // Same signs add magnitudes with clamping; opposite signs subtract the
    // smaller from the larger. A zero result is always forced to +0.
    always_comb begin
        resMag  = '0;
        resSign = 1'b0;
        sat_o   = 1'b0;
        if (signA == signB) begin
            resSign = signA;
            if (magSum > MaxMagW) begin
                resMag = MaxMagW[n-2:0];
                sat_o  = 1'b1;
            end else begin
                resMag = magSum[n-2:0];
            end
        end else if (magA >= magB) begin
            resMag  = magA - magB;
            resSign = signA;
        end else begin
            resMag  = magB - magA;
            resSign = signB;
        end
        if (resMag == '0) begin
            resSign = 1'b0;
        end
        sum_o = {resSign, resMag};
    end

endmodule

// File: rtl/sm_accum.sv
// Streaming sign-magnitude accumulator: sums a burst of operands over a
// valid/ready input and presents the saturated total, sticky overflow and
// operand count on a registered valid/ready output.
module sm_accum
    import sm_pkg::*;
#(
    parameter int n  = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [n-1:0]  in_data,
    input  logic          in_sub,
    input  logic          in_last,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [n-1:0]  out_data,
    output logic          out_ovf,
    output logic [CW-1:0] out_cnt
);

    localparam logic [CW-1:0] CntMax = '1;

    smState_e      state_q;
    smState_e      state_d;
    logic [n-1:0]  acc_q;
    logic [n-1:0]  acc_d;
    logic          ovf_q;
    logic          ovf_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [n-1:0]  outData_q;
    logic          outOvf_q;
    logic [CW-1:0] outCnt_q;

    logic          accept;
    logic          release_w;
    logic [n-1:0]  operand;
    logic [n-1:0]  addSum;
    logic          addSat;

    // A zero magnitude becomes +0; otherwise in_sub flips the sign.
    assign operand = (in_data[n-2:0] == '0) ? '0
                   : {in_data[n-1] ^ in_sub, in_data[n-2:0]};

    sm_add_sat #(.n(n)) u_add (
        .a_i   (acc_q),
        .b_i   (operand),
        .sum_o (addSum),
        .sat_o (addSat)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accepts move towards HOLD, out handshake returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    state_d = in_last ? HOLD : ACC;
                end
            end
            HOLD: begin
                if (out_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs derived from state only; in_rdy is held low during reset.
    always_comb begin
        in_rdy    = rst_n && (state_q != HOLD);
        out_vld   = (state_q == HOLD);
        accept    = in_vld && in_rdy;
        release_w = (state_q == HOLD) && out_rdy;
    end

    // Accumulator, sticky overflow and saturating counter next values.
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        if (accept) begin
            acc_d = addSum;
            ovf_d = ovf_q | addSat;
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CW'(1);
        end else if (release_w) begin
            acc_d = '0;
            ovf_d = 1'b0;
            cnt_d = '0;
        end
    end

    // Burst state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
        end
    end

    // Result registers capture the final totals on the last accept and stay frozen in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outData_q <= '0;
            outOvf_q  <= 1'b0;
            outCnt_q  <= '0;
        end else if (accept && in_last) begin
            outData_q <= acc_d;
            outOvf_q  <= ovf_d;
            outCnt_q  <= cnt_d;
        end
    end

    assign out_data = outData_q;
    assign out_ovf  = outOvf_q;
    assign out_cnt  = outCnt_q;

endmodule

// File: tb/tb_sm_accum.sv
// Directed scoreboard bench for sm_accum with an integer reference model.
module tb_sm_accum;

    logic       clk;
    logic       rst_n;
    logic       in_vld;
    logic       in_rdy;
    logic [7:0] in_data;
    logic       in_sub;
    logic       in_last;
    logic       out_vld;
    logic       out_rdy;
    logic [7:0] out_data;
    logic       out_ovf;
    logic [7:0] out_cnt;

    typedef struct {
        logic [7:0] data;
        logic       ovf;
        logic [7:0] cnt;
    } result_t;

    result_t sb[$];

    int total = 0;
    int bad   = 0;

    int modelSum = 0;
    bit modelOvf = 0;
    int modelCnt = 0;

    int waits;

    sm_accum #(.n(8), .CW(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .in_sub   (in_sub),
        .in_last  (in_last),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_ovf  (out_ovf),
        .out_cnt  (out_cnt)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Convert a sign-magnitude operand (with optional subtract) to an integer.
    function automatic int smToInt(input logic [7:0] v, input logic sub);
        int mag;
        mag = int'(v[6:0]);
        if (mag == 0) return 0;
        return (v[7] ^ sub) ? -mag : mag;
    endfunction

    // Convert a clamped integer back to sign-magnitude; zero is +0.
    function automatic logic [7:0] intToSm(input int s);
        logic [6:0] m;
        if (s < 0) begin
            m = 7'(-s);
            return {1'b1, m};
        end
        m = 7'(s);
        return {1'b0, m};
    endfunction

    // One comparison with an immediate assertion.
    task automatic checkVal(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one operand, wait (bounded) for acceptance and update the model.
    task automatic applyStimulus(input logic [7:0] d, input logic sub,
                                 input logic last, output int waited);
        bit got;
        int s;
        in_vld  = 1'b1;
        in_data = d;
        in_sub  = sub;
        in_last = last;
        got     = 0;
        waited  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_rdy === 1'b1) begin
                got = 1;
                break;
            end
            waited++;
        end
        if (!got) begin
            checkVal("accept_timeout", 32'(got), 32'd1);
        end else begin
            @(posedge clk);
            s = modelSum + smToInt(d, sub);
            if (s > 127) begin
                s = 127;
                modelOvf = 1;
            end else if (s < -127) begin
                s = -127;
                modelOvf = 1;
            end
            modelSum = s;
            if (modelCnt < 255) modelCnt++;
            if (last) begin
                sb.push_back('{data: intToSm(modelSum), ovf: modelOvf, cnt: 8'(modelCnt)});
                modelSum = 0;
                modelOvf = 0;
                modelCnt = 0;
            end
        end
        #1;
        in_vld  = 1'b0;
        in_last = 1'b0;
        in_sub  = 1'b0;
    endtask

    // Wait (bounded) for a result, compare it with the scoreboard, then release it.
    task automatic checkOutput();
        bit got;
        result_t exp;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_vld === 1'b1) begin
                got = 1;
                break;
            end
        end
        checkVal("out_vld_seen", 32'(got), 32'd1);
        if (got) begin
            if (sb.size() == 0) begin
                checkVal("sb_empty", 32'(sb.size()), 32'd1);
            end else begin
                exp = sb.pop_front();
                checkVal("out_data", 32'(out_data), 32'(exp.data));
                checkVal("out_ovf", 32'(out_ovf), 32'(exp.ovf));
                checkVal("out_cnt", 32'(out_cnt), 32'(exp.cnt));
                checkVal("in_rdy_hold", 32'(in_rdy), 32'd0);
            end
            out_rdy = 1'b1;
            @(posedge clk);
            #1;
            out_rdy = 1'b0;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        in_data = '0;
        in_sub  = 1'b0;
        in_last = 1'b0;
        out_rdy = 1'b0;

        // Reset state.
        #12;
        checkVal("rst_in_rdy", 32'(in_rdy), 32'd0);
        checkVal("rst_out_vld", 32'(out_vld), 32'd0);
        checkVal("rst_out_data", 32'(out_data), 32'd0);
        checkVal("rst_out_ovf", 32'(out_ovf), 32'd0);
        checkVal("rst_out_cnt", 32'(out_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkVal("rel_in_rdy", 32'(in_rdy), 32'd1);
        @(posedge clk);
        #1;

        // Mixed add/subtract burst and result latency.
        applyStimulus(8'h05, 1'b0, 1'b0, waits);
        applyStimulus(8'h83, 1'b0, 1'b0, waits);
        applyStimulus(8'h0A, 1'b0, 1'b1, waits);
        @(negedge clk);
        checkVal("latency_out_vld", 32'(out_vld), 32'd1);
        checkOutput();

        // Saturation, then a follow-up burst showing the flag cleared.
        applyStimulus(8'h64, 1'b0, 1'b0, waits);
        applyStimulus(8'h32, 1'b0, 1'b1, waits);
        checkOutput();
        applyStimulus(8'h7F, 1'b0, 1'b0, waits);
        applyStimulus(8'h81, 1'b0, 1'b1, waits);
        checkOutput();

        // Cancellation to +0 and a lone negative zero.
        applyStimulus(8'h07, 1'b0, 1'b0, waits);
        applyStimulus(8'h87, 1'b0, 1'b1, waits);
        checkOutput();
        applyStimulus(8'h80, 1'b0, 1'b1, waits);
        checkOutput();

        // Subtract flag.
        applyStimulus(8'h14, 1'b1, 1'b0, waits);
        applyStimulus(8'h05, 1'b0, 1'b1, waits);
        checkOutput();

        // Accumulation continues from the clamped value; overflow stays sticky.
        applyStimulus(8'h7F, 1'b0, 1'b0, waits);
        applyStimulus(8'h01, 1'b0, 1'b0, waits);
        applyStimulus(8'hFF, 1'b0, 1'b1, waits);
        checkOutput();

        // Back-pressure: result frozen and input stalled while out_rdy is low.
        applyStimulus(8'h01, 1'b0, 1'b1, waits);
        in_vld  = 1'b1;
        in_data = 8'h02;
        in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkVal("bp_in_rdy", 32'(in_rdy), 32'd0);
            checkVal("bp_out_vld", 32'(out_vld), 32'd1);
            checkVal("bp_out_data", 32'(out_data), 32'h01);
            checkVal("bp_out_cnt", 32'(out_cnt), 32'd1);
        end
        checkOutput();
        applyStimulus(8'h02, 1'b0, 1'b1, waits);
        checkVal("bp_next_accept_wait", 32'(waits), 32'd0);
        checkOutput();

        // Asynchronous reset mid-burst discards the partial sum.
        applyStimulus(8'h10, 1'b0, 1'b0, waits);
        applyStimulus(8'h20, 1'b0, 1'b0, waits);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("mid_rst_in_rdy", 32'(in_rdy), 32'd0);
        checkVal("mid_rst_out_vld", 32'(out_vld), 32'd0);
        checkVal("mid_rst_out_data", 32'(out_data), 32'd0);
        checkVal("mid_rst_out_ovf", 32'(out_ovf), 32'd0);
        checkVal("mid_rst_out_cnt", 32'(out_cnt), 32'd0);
        modelSum = 0;
        modelOvf = 0;
        modelCnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(8'h03, 1'b0, 1'b1, waits);
        checkOutput();

        checkVal("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
